// File: rtl/rv_pkg.sv
// Shared RV32I front-end definitions: widths, default reset PC, fetch FSM states
// and the fetch-buffer entry layout.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH,
        WAIT
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// Fetch buffer: small synchronous FIFO of {inst, pc} entries between IF and ID.
// Clear wins over push and pop; the head output holds its last value when empty.
module if_fetch_buf
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    clear,
    input  fetch_entry_t            din,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    valid,
    output fetch_entry_t            head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    fetch_entry_t mem [DEPTH];
    fetch_entry_t last;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign valid = (count != '0);
    assign head  = valid ? mem[rd_ptr] : last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            // Remember whatever ID currently sees so it stays visible once empty.
            if (valid) begin
                last <= mem[rd_ptr];
            end
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // The request throttle upstream must make an overflowing push impossible.
    assert property (@(posedge clk) disable iff (rst) !(push && !clear && count == FULL));

endmodule

// File: rtl/if_fetch.sv
// RV32I IF stage: owns the PC, issues one instruction-memory request at a time,
// buffers returned words for ID and squashes wrong-path fetches on EX redirects.
module if_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic [31:0] ex_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(BUF_DEPTH);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] req_pc;
    logic            kill;
    logic            kill_next;
    logic            outstanding;
    logic            redirect;
    logic            grant;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    logic [CW:0]     in_flight;
    fetch_entry_t    din;
    fetch_entry_t    head;
    logic            unused_target_lsbs;

    assign redirect    = ex_branch | ex_jump;
    assign outstanding = (state == WAIT);
    assign in_flight   = {1'b0, count} + {{CW{1'b0}}, outstanding};

    // Reserve a buffer slot for every in-flight word so a response always fits.
    assign imem_req  = ~rst & (state == FETCH) & (in_flight < DEPTH_LIM) & ~redirect;
    assign imem_addr = pc;
    assign grant     = imem_req & imem_gnt;
    assign pop       = id_ready & if_valid & ~redirect;
    assign din       = {imem_rdata, req_pc};
    assign if_inst   = head.inst;
    assign if_pc     = head.pc;

    // Redirect targets are word-aligned by masking; misalignment is not trapped here.
    assign unused_target_lsbs = ^ex_target[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            kill  <= kill_next;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            req_pc <= pc;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        kill_next  = kill;
        push       = 1'b0;
        case (state)
            FETCH: begin
                if (grant) begin
                    state_next = WAIT;
                    pc_next    = pc + 32'd4;
                end
            end
            WAIT: begin
                // A response landing with a redirect, or after one, is wrong-path.
                if (imem_rvalid) begin
                    state_next = FETCH;
                    kill_next  = 1'b0;
                    push       = ~kill & ~redirect;
                end else if (redirect) begin
                    kill_next = 1'b1;
                end
            end
            default: ;
        endcase
        if (redirect) begin
            pc_next = {ex_target[31:2], 2'b00};
        end
    end

    if_fetch_buf #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   (din),
        .count (count),
        .valid (if_valid),
        .head  (head)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus random traffic, all checked against
// a queue-based behavioural model of the fetch stage.
module tb_if_fetch;
    import rv_pkg::*;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ex_branch;
    logic        ex_jump;
    logic [31:0] ex_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ex_branch   (ex_branch),
        .ex_jump     (ex_jump),
        .ex_target   (ex_target),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    fetch_entry_t q[$];
    fetch_entry_t m_last;
    logic [31:0]  m_pc;
    logic [31:0]  m_req_pc;
    bit           m_out;
    bit           m_kill;

    // Instruction memory model state
    bit          mem_pend = 0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;

    logic [31:0] seen[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0013};
    endfunction

    task automatic model_reset();
        q.delete();
        m_last   = '0;
        m_pc     = RESET_PC;
        m_req_pc = '0;
        m_out    = 0;
        m_kill   = 0;
    endtask

    // Called at posedge+1; drives one cycle, checks at negedge, advances the model.
    task automatic step(input bit gnt, input int lat, input bit rdy, input bit br,
                        input bit jp, input logic [31:0] tgt, input bit spur);
        bit red, mreq, push, pop, out_n, kill_n;
        fetch_entry_t pe;
        imem_gnt    = gnt;
        id_ready    = rdy;
        ex_branch   = br;
        ex_jump     = jp;
        ex_target   = tgt;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_pend    = 0;
            end
        end else if (spur) begin
            imem_rvalid = 1'b1;
        end
        @(negedge clk);
        red  = br | jp;
        mreq = !m_out && (q.size() + int'(m_out) < BUF_DEPTH) && !red;
        check("imem_req", imem_req, mreq);
        if (mreq) check("imem_addr", imem_addr, m_pc);
        check("if_valid", if_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("if_inst", if_inst, q[0].inst);
            check("if_pc", if_pc, q[0].pc);
            m_last = q[0];
        end else begin
            check("if_inst_hold", if_inst, m_last.inst);
            check("if_pc_hold", if_pc, m_last.pc);
        end
        if (if_valid && rdy && !red) seen.push_back(if_pc);
        if (imem_req && imem_gnt) begin
            mem_pend = 1;
            mem_cnt  = lat;
            mem_addr = imem_addr;
        end
        pe.inst = imem_rdata;
        pe.pc   = m_req_pc;
        push    = 0;
        out_n   = m_out;
        kill_n  = m_kill;
        if (m_out && imem_rvalid) begin
            push   = !m_kill && !red;
            out_n  = 0;
            kill_n = 0;
        end else if (m_out && red) begin
            kill_n = 1;
        end
        pop = rdy && q.size() != 0 && !red;
        if (mreq && gnt) begin
            out_n    = 1;
            m_req_pc = m_pc;
            m_pc     = m_pc + 32'd4;
        end
        if (red) begin
            q.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(pe);
        end
        m_out  = out_n;
        m_kill = kill_n;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        ex_branch   = 1'b0;
        ex_jump     = 1'b0;
        id_ready    = 1'b0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_inst", if_inst, 0);
        check("rst_pc", if_pc, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Checks that a request to addr is being presented right now with idle inputs.
    task automatic probe(input string tag, input logic [31:0] addr);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        ex_branch   = 1'b0;
        ex_jump     = 1'b0;
        #1;
        check({tag, "_req"}, imem_req, 1);
        check({tag, "_addr"}, imem_addr, addr);
        check({tag, "_valid"}, if_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int guard;
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        ex_branch   = 1'b0;
        ex_jump     = 1'b0;
        ex_target   = '0;
        id_ready    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Streaming: grant every cycle, 1-cycle response, ID always ready
        seen.delete();
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, '0, 0);
        for (int k = 0; k < 3; k++)
            check("t1_pop_pc", (k < seen.size()) ? seen[k] : 32'hDEAD_BEEF, 32'(k * 4));

        // ID stalled: buffer fills to two entries and requests stop
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, '0, 0);
        check("t2_req_off", imem_req, 0);
        check("t2_head_pc", if_pc, 32'h0);
        check("t2_head_inst", if_inst, mem_word(32'h0));
        seen.delete();
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, '0, 0);
        check("t2_pop0", (seen.size() > 0) ? seen[0] : 32'hDEAD_BEEF, 32'h0);
        check("t2_pop1", (seen.size() > 1) ? seen[1] : 32'hDEAD_BEEF, 32'h4);

        // Branch while the request to 0x10 is in flight
        do_reset();
        guard = 0;
        while (!(m_out && m_req_pc == 32'h10) && guard < 60) begin
            step(1, 3, 1, 0, 0, '0, 0);
            guard++;
        end
        check("t3_setup", guard < 60, 1);
        step(1, 3, 1, 1, 0, 32'h100, 0);
        guard = 0;
        while (q.size() == 0 && guard < 40) begin
            step(1, 3, 0, 0, 0, '0, 0);
            guard++;
        end
        check("t3_first_pc", if_pc, 32'h100);
        check("t3_first_inst", if_inst, mem_word(32'h100));

        // Redirect coinciding with a response and with an ID pop
        do_reset();
        guard = 0;
        while (!(q.size() != 0 && m_out && mem_pend && mem_cnt == 1) && guard < 60) begin
            step(1, 2, 0, 0, 0, '0, 0);
            guard++;
        end
        check("t5_setup", guard < 60, 1);
        step(1, 2, 1, 1, 0, 32'h300, 0);
        probe("t5", 32'h300);

        // Jump to a misaligned target is word aligned
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, '0, 0);
        step(0, 1, 1, 0, 1, 32'h203, 0);
        probe("t4", 32'h200);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, '0, 0);

        // Reset in the middle of a wait; the stale response must be ignored
        do_reset();
        step(1, 3, 1, 0, 0, '0, 0);
        step(1, 3, 1, 0, 0, '0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, '0, 0);
        check("t6_no_stale", if_valid, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, '0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          g, r, b, j, s;
            int          l, sel;
            logic [31:0] t;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                g   = ($urandom_range(0, 3) != 0);
                l   = $urandom_range(1, 4);
                r   = ($urandom_range(0, 2) != 0);
                sel = $urandom_range(0, 15);
                b   = (sel == 0) || (sel == 2);
                j   = (sel == 1) || (sel == 2);
                if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else t = $urandom & 32'h0000_0FFF;
                s   = ($urandom_range(0, 15) == 0);
                step(g, l, r, b, j, t, s);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- RV32I IF-stage fetch unit: holds the PC, issues instruction-memory requests and buffers returned words for ID.
- Consumes the EX-stage branch decision and target, redirects the PC, and flushes wrong-path instructions, including in-flight ones.
- Sits between instruction memory and the IF/ID boundary.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
BUF_DEPTH, 2, fetch-buffer entries (power of two, >= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (word aligned)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid (in order, >= 1 cycle after gnt)
imem_rdata  input  32  instruction word
ex_branch  input  1  conditional branch taken (EX ALU branch output)
ex_jump  input  1  JAL/JALR in EX
ex_target  input  32  redirect target from EX
id_ready  input  1  ID accepts head entry
if_valid  output  1  buffer head valid
if_inst  output  32  head instruction
if_pc  output  32  PC of head instruction

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - pc = RESET_PC, buffer empty, outstanding = 0, kill = 0, state = FETCH.
  - imem_req = 0, if_valid = 0, if_inst = 0, if_pc = 0.
  - First request is issued in the first cycle after rst deasserts.
- Definitions:
  - redirect = ex_branch | ex_jump.
  - Redirect PC = {ex_target[31:2], 2'b00`}; the low bits are masked and no misalign trap is raised here.
- Request rule: imem_req = (state == FETCH) & (count + outstanding < BUF_DEPTH) & ~redirect. This is combinational.
- imem_addr = pc, held stable while imem_req is high and imem_gnt is low.
- On imem_req & imem_gnt:
  - outstanding <= 1, state <= WAIT.
  - pc <= pc + 4 (32-bit wrap, 0xFFFF_FFFC -> 0).
  - The issued PC is latched as req_pc.
- Only one outstanding request at a time.
- States:
  - FETCH: request eligible; goes to WAIT on grant.
  - WAIT: waiting for imem_rvalid; returns to FETCH on rvalid.
- Response in WAIT with imem_rvalid:
  - If kill = 0 and no redirect this cycle: push {imem_rdata, req_pc}.
  - Otherwise drop the word and clear kill.
- Pop: id_ready & if_valid & ~redirect. Push and pop in the same cycle are both performed; count is unchanged.
- Redirect (highest priority):
  - pc <= target, buffer cleared, no pop, imem_req forced 0.
  - If outstanding and rvalid is not in this cycle, kill <= 1.
  - State returns to FETCH once any killed response has drained; the first request on the target is issued the next eligible cycle.
- Redirect while kill is already set: kill stays 1 and pc is updated to the new target.
- Full buffer: requests are suppressed by the count rule, so an overflow push is impossible. An assertion fires if a push occurs when count == BUF_DEPTH.
- Empty buffer: if_valid = 0; if_inst/if_pc hold their last value.
- Latency: grant at t, rvalid at t+k, if_valid at t+k+1. No bypass.
- Reset mid-operation: all state is cleared immediately; a later rvalid for a pre-reset request is ignored because outstanding = 0.
- imem_rvalid with outstanding = 0 is ignored.

Decomposition:
- Shared package (rv_pkg):
  - XLEN = 32, RESET_PC default, INST_NOP = 32'h0000_0013.
  - Fetch-state enum FETCH/WAIT, fetch-entry struct {inst[31:0], pc[31:0]}.
- Sub-module if_fetch_buf: synchronous FIFO of fetch entries with push, pop, clear, count, head outputs; clear has priority over push and pop.
- if_fetch holds the PC, FSM, kill flag and request logic.

Test Plan:
- Reset release, imem grants every cycle with 1-cycle rvalid, id_ready = 1 -> addresses 0x0, 0x4, 0x8; if_pc sequence 0x0, 0x4, 0x8 with the matching rdata; first if_valid in the cycle after the first rvalid.
- id_ready = 0 for 10 cycles -> exactly 2 entries buffered, imem_req low afterwards; releasing id_ready pops 0x0 then 0x4 and requesting resumes at 0x8.
- ex_branch = 1, ex_target = 0x100 while a request to 0x10 is outstanding -> response for 0x10 dropped, buffer flushed; next imem_addr = 0x100; if_pc 0x100 appears with no stale entries.
- ex_jump with ex_target = 0x203 -> imem_addr = 0x200.
- Redirect in the same cycle as imem_rvalid and as an id_ready pop -> word dropped, no pop counted, kill stays 0, next request at the target.
- rst asserted mid-WAIT, then rvalid arrives -> outputs zero immediately, rvalid ignored, fetch restarts at RESET_PC.
